// File: rtl/alu.sv
// Single-cycle ALU with combinational flags and a registered sticky overflow flag.
// Optional shift operations (SLL/SRL/SRA) are compiled in when ALU_SHIFT_EN is defined.
module alu #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [3:0]      i_control,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_clr_sticky,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_negative,
    output logic            o_overflow,
    output logic            o_carry,
    output logic            o_ovf_sticky
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;

`ifdef ALU_SHIFT_EN
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam int         SHW     = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = i_b[SHW-1:0];
`endif

    // One extra bit on both paths: bit XLEN is ADD carry-out, and for SUB it is the borrow.
    logic [XLEN:0] add_full;
    logic [XLEN:0] sub_full;
    logic          add_ovf;
    logic          sub_ovf;
    logic          slt;
    logic          sltu;
    logic          sticky;

    assign add_full = {1'b0, i_a} + {1'b0, i_b};
    assign sub_full = {1'b0, i_a} - {1'b0, i_b};
    assign add_ovf  = (i_a[XLEN-1] == i_b[XLEN-1]) && (add_full[XLEN-1] != i_a[XLEN-1]);
    assign sub_ovf  = (i_a[XLEN-1] != i_b[XLEN-1]) && (sub_full[XLEN-1] != i_a[XLEN-1]);
    assign slt      = $signed(i_a) < $signed(i_b);
    assign sltu     = i_a < i_b;

    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        o_carry    = 1'b0;
        case (i_control)
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_ADD: begin
                o_result   = add_full[XLEN-1:0];
                o_overflow = add_ovf;
                o_carry    = add_full[XLEN];
            end
            OP_SUB: begin
                o_result   = sub_full[XLEN-1:0];
                o_overflow = sub_ovf;
                o_carry    = ~sub_full[XLEN];
            end
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, slt};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, sltu};
`ifdef ALU_SHIFT_EN
            OP_SLL:  o_result = i_a << shamt;
            OP_SRL:  o_result = i_a >> shamt;
            OP_SRA:  o_result = $signed(i_a) >>> shamt;
`endif
            default: o_result = '0;
        endcase
    end

    assign o_zero     = (o_result == '0);
    assign o_negative = o_result[XLEN-1];

    // Clear has priority over a same-cycle overflow so software never misses a fresh clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sticky <= 1'b0;
        end else if (i_clr_sticky) begin
            sticky <= 1'b0;
        end else if (o_overflow) begin
            sticky <= 1'b1;
        end
    end

    assign o_ovf_sticky = sticky;

endmodule

// File: tb/tb_alu.sv
// Directed-vector testbench for alu (64-bit); shift vectors are selected by ALU_SHIFT_EN.
module tb_alu;

    localparam int XLEN = 64;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAX_POS  = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;

    logic            i_clk;
    logic            i_rst;
    logic [3:0]      i_control;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            i_clr_sticky;
    logic [XLEN-1:0] o_result;
    logic            o_zero;
    logic            o_negative;
    logic            o_overflow;
    logic            o_carry;
    logic            o_ovf_sticky;

    int error_count;
    int check_count;

    alu #(.XLEN(XLEN)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_control   (i_control),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_clr_sticky(i_clr_sticky),
        .o_result    (o_result),
        .o_zero      (o_zero),
        .o_negative  (o_negative),
        .o_overflow  (o_overflow),
        .o_carry     (o_carry),
        .o_ovf_sticky(o_ovf_sticky)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic applyStimulus(input logic [3:0] ctrl, input logic [63:0] a, input logic [63:0] b);
        i_control = ctrl;
        i_a       = a;
        i_b       = b;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        error_count  = 0;
        check_count  = 0;
        i_rst        = 1'b1;
        i_clr_sticky = 1'b0;
        applyStimulus(OP_AND, 64'd0, 64'd0);
        tick();
        checkOutput("reset_sticky", {63'd0, o_ovf_sticky}, 64'd0);
        i_rst = 1'b0;

        applyStimulus(OP_ADD, 64'd5, 64'd7);
        checkOutput("add_result", o_result, 64'd12);
        checkOutput("add_zero", {63'd0, o_zero}, 64'd0);
        checkOutput("add_carry", {63'd0, o_carry}, 64'd0);
        checkOutput("add_ovf", {63'd0, o_overflow}, 64'd0);

        applyStimulus(OP_SUB, 64'd9, 64'd9);
        checkOutput("sub_eq_result", o_result, 64'd0);
        checkOutput("sub_eq_zero", {63'd0, o_zero}, 64'd1);
        checkOutput("sub_eq_carry", {63'd0, o_carry}, 64'd1);

        applyStimulus(OP_SUB, 64'd0, 64'd1);
        checkOutput("sub_borrow_result", o_result, ALL_ONES);
        checkOutput("sub_borrow_neg", {63'd0, o_negative}, 64'd1);
        checkOutput("sub_borrow_carry", {63'd0, o_carry}, 64'd0);

        applyStimulus(OP_ADD, ALL_ONES, 64'd1);
        checkOutput("add_wrap_result", o_result, 64'd0);
        checkOutput("add_wrap_carry", {63'd0, o_carry}, 64'd1);
        checkOutput("add_wrap_ovf", {63'd0, o_overflow}, 64'd0);

        applyStimulus(OP_SUB, MIN_NEG, 64'd1);
        checkOutput("sub_ovf_result", o_result, MAX_POS);
        checkOutput("sub_ovf_flag", {63'd0, o_overflow}, 64'd1);
        checkOutput("sub_ovf_carry", {63'd0, o_carry}, 64'd1);

        // Sticky set, hold, and clear.
        i_clr_sticky = 1'b1;
        tick();
        i_clr_sticky = 1'b0;
        applyStimulus(OP_ADD, MAX_POS, 64'd1);
        checkOutput("add_ovf_flag", {63'd0, o_overflow}, 64'd1);
        checkOutput("add_ovf_result", o_result, MIN_NEG);
        checkOutput("add_ovf_neg", {63'd0, o_negative}, 64'd1);
        checkOutput("sticky_before_edge", {63'd0, o_ovf_sticky}, 64'd0);
        tick();
        checkOutput("sticky_set", {63'd0, o_ovf_sticky}, 64'd1);
        applyStimulus(OP_AND, 64'hF0, 64'h3C);
        tick();
        checkOutput("sticky_hold", {63'd0, o_ovf_sticky}, 64'd1);
        i_clr_sticky = 1'b1;
        tick();
        i_clr_sticky = 1'b0;
        checkOutput("sticky_clear", {63'd0, o_ovf_sticky}, 64'd0);

        // Clear wins over a simultaneous overflow.
        applyStimulus(OP_ADD, MAX_POS, 64'd1);
        tick();
        checkOutput("sticky_reset_again", {63'd0, o_ovf_sticky}, 64'd1);
        i_clr_sticky = 1'b1;
        tick();
        checkOutput("clr_over_ovf", {63'd0, o_ovf_sticky}, 64'd0);
        i_clr_sticky = 1'b0;
        tick();
        checkOutput("sticky_reset_by_ovf", {63'd0, o_ovf_sticky}, 64'd1);

        // Reset held across several edges with overflow present.
        i_rst = 1'b1;
        tick();
        checkOutput("rst_ovf_sticky", {63'd0, o_ovf_sticky}, 64'd0);
        checkOutput("rst_comb_tracks", {63'd0, o_overflow}, 64'd1);
        tick();
        checkOutput("rst_hold_sticky", {63'd0, o_ovf_sticky}, 64'd0);
        i_clr_sticky = 1'b1;
        tick();
        checkOutput("rst_clr_ovf_sticky", {63'd0, o_ovf_sticky}, 64'd0);
        i_rst        = 1'b0;
        i_clr_sticky = 1'b0;

        applyStimulus(OP_SLT, ALL_ONES, 64'd1);
        checkOutput("slt_neg", o_result, 64'd1);
        applyStimulus(OP_SLT, 64'd1, ALL_ONES);
        checkOutput("slt_pos", o_result, 64'd0);
        applyStimulus(OP_SLTU, ALL_ONES, 64'd1);
        checkOutput("sltu_big", o_result, 64'd0);
        applyStimulus(OP_SLTU, 64'd1, ALL_ONES);
        checkOutput("sltu_small", o_result, 64'd1);
        checkOutput("sltu_carry", {63'd0, o_carry}, 64'd0);
        applyStimulus(OP_AND, 64'hF0, 64'h3C);
        checkOutput("and", o_result, 64'h30);
        applyStimulus(OP_OR, 64'hF0, 64'h0F);
        checkOutput("or", o_result, 64'hFF);
        applyStimulus(OP_NOR, 64'd0, 64'd0);
        checkOutput("nor", o_result, ALL_ONES);
        applyStimulus(OP_XOR, 64'hFF, 64'h0F);
        checkOutput("xor", o_result, 64'hF0);

        applyStimulus(4'b1111, ALL_ONES, ALL_ONES);
        checkOutput("undecoded_result", o_result, 64'd0);
        checkOutput("undecoded_zero", {63'd0, o_zero}, 64'd1);
        checkOutput("undecoded_ovf", {63'd0, o_overflow}, 64'd0);

`ifdef ALU_SHIFT_EN
        applyStimulus(OP_SLL, 64'd1, 64'd65);
        checkOutput("sll", o_result, 64'd2);
        applyStimulus(OP_SRA, MIN_NEG, 64'd63);
        checkOutput("sra", o_result, ALL_ONES);
        applyStimulus(OP_SRL, MIN_NEG, 64'd63);
        checkOutput("srl", o_result, 64'd1);
`else
        applyStimulus(OP_SLL, 64'd1, 64'd1);
        checkOutput("sll_off_result", o_result, 64'd0);
        checkOutput("sll_off_zero", {63'd0, o_zero}, 64'd1);
        applyStimulus(OP_SRL, MIN_NEG, 64'd63);
        checkOutput("srl_off_result", o_result, 64'd0);
        applyStimulus(OP_SRA, MIN_NEG, 64'd63);
        checkOutput("sra_off_result", o_result, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have port i_clk, input, 1, single clock, rising-edge active.
REQ-003 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port i_control, input, 4, operation select.
REQ-005 SHALL have port i_a, input, XLEN, operand A.
REQ-006 SHALL have port i_b, input, XLEN, operand B or shift amount.
REQ-007 SHALL have port i_clr_sticky, input, 1, clears the sticky overflow flag.
REQ-008 SHALL have port o_result, output, XLEN, operation result, combinational.
REQ-009 SHALL have port o_zero, output, 1, high iff o_result is all zeros, combinational.
REQ-010 SHALL have port o_negative, output, 1, equal to o_result[XLEN-1], combinational.
REQ-011 SHALL have port o_overflow, output, 1, signed overflow of ADD/SUB, combinational.
REQ-012 SHALL have port o_carry, output, 1, ADD carry-out or SUB no-borrow, combinational.
REQ-013 SHALL have port o_ovf_sticky, output, 1, registered OR of o_overflow since last clear.

Function
REQ-014 SHALL decode i_control: 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0110 SUB (A-B); 0111 SLT signed; 1000 SLTU unsigned; 1100 NOR.
REQ-015 SHALL, when ALU_SHIFT_EN is defined, also decode 0100 SLL, 0101 SRL and 1101 SRA, using shift amount i_b[log2(XLEN)-1:0] with upper i_b bits ignored.
REQ-016 SHALL output zero-extended 1 or 0 in o_result for SLT and SLTU.
REQ-017 SHALL drive o_result to 0 for every undecoded code, which therefore forces o_zero to 1.
REQ-018 SHALL compute o_result, o_zero, o_negative, o_overflow and o_carry with zero-cycle latency, no clock dependency.
REQ-019 SHALL wrap ADD and SUB modulo 2^XLEN.
REQ-020 SHALL set o_overflow only for ADD/SUB when operand signs imply a wrong result sign; 0 otherwise.
REQ-021 SHALL set o_carry for ADD to the bit-XLEN carry-out, for SUB to 1 iff i_a >= i_b unsigned, and to 0 for all other ops.
REQ-022 SHALL update o_ovf_sticky on each rising i_clk edge; priority: i_rst -> 0, then i_clr_sticky -> 0, then o_overflow=1 -> 1, else hold.
REQ-023 SHALL give i_clr_sticky priority over a simultaneous overflow.

Reset
REQ-024 SHALL clear o_ovf_sticky to 0 on the first rising edge with i_rst high; combinational outputs SHALL track inputs regardless of i_rst.
REQ-025 SHALL hold o_ovf_sticky at 0 for every edge i_rst stays high, including mid-operation.

Configuration
REQ-026 SHALL compile shift operations in only when macro ALU_SHIFT_EN is defined; without it, codes 0100/0101/1101 behave as undecoded per REQ-017.

Verification
REQ-027 ADD a=5, b=7 -> o_result=12, o_zero=0, o_carry=0, o_overflow=0.
REQ-028 SUB a=9, b=9 -> o_result=0, o_zero=1, o_carry=1; SUB a=0, b=1 -> result all ones, o_negative=1, o_carry=0.
REQ-029 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> o_overflow=1, o_result=0x8000_0000_0000_0000; next edge o_ovf_sticky=1; holds after operands change; i_clr_sticky=1 for one edge -> 0.
REQ-030 SLT a=-1, b=1 -> 1; SLTU a=-1, b=1 -> 0; AND 0xF0&0x3C=0x30; OR 0xF0|0x0F=0xFF; NOR 0,0 -> all ones; XOR 0xFF^0x0F=0xF0.
REQ-031 With ALU_SHIFT_EN: SLL a=1, b=65 -> 2; SRA a=0x8000_0000_0000_0000, b=63 -> all ones; SRL same -> 1; without macro, code 0100 -> 0, o_zero=1.
REQ-032 Overflow with i_rst=1 and i_clr_sticky=1 simultaneously -> o_ovf_sticky stays 0.
